// File: rtl/ra_flit_injector.sv
// rtl/ra_flit_injector.sv - two-source RA flit injector with per-VC credits and packet-level round-robin
module ra_flit_injector #(
    parameter int DATA_WIDTH = 32,
    parameter int VC_BITS    = 1,
    parameter int ID_BITS    = 4,
    parameter int EXTRA      = 2,
    parameter int TYPE_BITS  = 2,
    parameter int BUF_DEPTH  = 4,
    localparam int VC_PER_PORTS = 1 << VC_BITS,
    localparam int FLIT_WIDTH   = 2*ID_BITS + EXTRA + TYPE_BITS + VC_BITS + DATA_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [FLIT_WIDTH-1:0]   req_flit,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [FLIT_WIDTH-1:0]   rsp_flit,
    input  logic                    rsp_valid,
    output logic                    rsp_ready,
    input  logic [VC_PER_PORTS-1:0] credit_in,
    output logic [FLIT_WIDTH-1:0]   out_flit,
    output logic                    out_valid,
    output logic [1:0]              err
);
    localparam int VC_LSB  = DATA_WIDTH;
    localparam int TY_LSB  = VC_LSB + VC_BITS;
    localparam int CLS_BIT = TY_LSB + TYPE_BITS + EXTRA - 1;
    localparam int CW      = $clog2(BUF_DEPTH + 1);
    localparam logic [TYPE_BITS-1:0] T_HEAD = TYPE_BITS'(2);
    localparam logic [TYPE_BITS-1:0] T_TAIL = TYPE_BITS'(1);
    localparam logic [TYPE_BITS-1:0] T_ALL  = TYPE_BITS'(3);

    typedef enum logic [1:0] {IDLE, LOCK_REQ, LOCK_RSP} state_t;

    logic [FLIT_WIDTH-1:0] r_mem [2][2];
    logic [1:0]            r_wptr, r_rptr;
    logic [1:0]            r_cnt [2];
    logic [CW-1:0]         r_credit [VC_PER_PORTS];
    state_t                r_state, w_state_nxt;
    logic                  r_rr, w_rr_nxt;

    logic [FLIT_WIDTH-1:0] w_in_flit [2];
    logic [FLIT_WIDTH-1:0] w_head [2];
    logic [VC_BITS-1:0]    w_head_vc [2];
    logic [1:0]            w_cnt_nxt [2];
    logic [1:0]            w_in_valid, w_elig, w_pop, w_push_ok;
    logic                  w_grant, w_gsrc;
    logic [TYPE_BITS-1:0]  w_gtype;
    logic [VC_BITS-1:0]    w_gvc;
    logic [FLIT_WIDTH-1:0] w_out;
    logic [VC_PER_PORTS-1:0] w_send_vc;

    assign w_in_flit[0] = req_flit;
    assign w_in_flit[1] = rsp_flit;
    assign w_in_valid   = {rsp_valid, req_valid};

    // Index 0 is REQ, index 1 is RSP; the traffic class bit picks the lowest or highest VC.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_head[s]    = r_mem[s][r_rptr[s]];
            w_head_vc[s] = w_head[s][CLS_BIT] ? VC_BITS'(VC_PER_PORTS - 1) : '0;
            w_elig[s]    = (r_cnt[s] != 2'd0) && (r_credit[w_head_vc[s]] != '0);
        end
    end

    always_comb begin
        w_grant     = 1'b0;
        w_gsrc      = 1'b0;
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        case (r_state)
            IDLE: begin
                w_grant = |w_elig;
                w_gsrc  = (&w_elig) ? ~r_rr : w_elig[1];
            end
            LOCK_REQ: begin
                w_grant = w_elig[0];
                w_gsrc  = 1'b0;
            end
            LOCK_RSP: begin
                w_grant = w_elig[1];
                w_gsrc  = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
        w_gtype = w_head[w_gsrc][TY_LSB +: TYPE_BITS];
        w_gvc   = w_head_vc[w_gsrc];
        // Stray BODY/TAIL while idle behaves like ALL so the link never wedges.
        if (w_grant) begin
            if (r_state == IDLE && w_gtype == T_HEAD) begin
                w_state_nxt = w_gsrc ? LOCK_RSP : LOCK_REQ;
            end else if (r_state == IDLE || w_gtype == T_TAIL || w_gtype == T_ALL) begin
                w_state_nxt = IDLE;
                w_rr_nxt    = w_gsrc;
            end
        end
        w_out = w_head[w_gsrc];
        w_out[VC_LSB +: VC_BITS] = w_gvc;
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_pop[s]     = w_grant && (w_gsrc == 1'(s));
            w_push_ok[s] = w_in_valid[s] && ((r_cnt[s] != 2'd2) || w_pop[s]);
            w_cnt_nxt[s] = r_cnt[s] + {1'b0, w_push_ok[s]} - {1'b0, w_pop[s]};
        end
        for (int v = 0; v < VC_PER_PORTS; v++) begin
            w_send_vc[v] = w_grant && (w_gvc == VC_BITS'(v));
        end
    end

    always_ff @(posedge clock) begin
        for (int s = 0; s < 2; s++) begin
            if (w_push_ok[s]) r_mem[s][r_wptr[s]] <= w_in_flit[s];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_cnt[0]  <= '0;
            r_cnt[1]  <= '0;
            for (int v = 0; v < VC_PER_PORTS; v++) r_credit[v] <= CW'(BUF_DEPTH);
            r_state   <= IDLE;
            r_rr      <= 1'b0;
            req_ready <= 1'b0;
            rsp_ready <= 1'b0;
            out_flit  <= '0;
            out_valid <= 1'b0;
            err       <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (w_push_ok[s]) r_wptr[s] <= ~r_wptr[s];
                if (w_pop[s])     r_rptr[s] <= ~r_rptr[s];
                if (w_in_valid[s] && !w_push_ok[s]) err[0] <= 1'b1;
                r_cnt[s] <= w_cnt_nxt[s];
            end
            // Ready only when empty: leaves one slot for a flit already launched.
            req_ready <= (w_cnt_nxt[0] == 2'd0);
            rsp_ready <= (w_cnt_nxt[1] == 2'd0);
            for (int v = 0; v < VC_PER_PORTS; v++) begin
                if (w_send_vc[v] && !credit_in[v]) begin
                    r_credit[v] <= r_credit[v] - 1'b1;
                end else if (!w_send_vc[v] && credit_in[v]) begin
                    if (r_credit[v] == CW'(BUF_DEPTH)) err[1] <= 1'b1;
                    else                               r_credit[v] <= r_credit[v] + 1'b1;
                end
            end
            r_state   <= w_state_nxt;
            r_rr      <= w_rr_nxt;
            out_valid <= w_grant;
            out_flit  <= w_grant ? w_out : '0;
        end
    end
endmodule

// File: tb/tb_ra_flit_injector.sv
// tb/tb_ra_flit_injector.sv - scoreboard bench for ra_flit_injector
module tb_ra_flit_injector;
    localparam logic [1:0] HEAD = 2'b10, BODY = 2'b00, TAIL = 2'b01, ALL = 2'b11;

    logic        clock, reset;
    logic [44:0] req_flit, rsp_flit, out_flit;
    logic        req_valid, rsp_valid, req_ready, rsp_ready, out_valid;
    logic [1:0]  credit_in, err;

    int errors = 0;
    int checks = 0;
    logic [44:0] sb[$];
    logic [44:0] exp_f;

    ra_flit_injector dut (
        .clock(clock), .reset(reset),
        .req_flit(req_flit), .req_valid(req_valid), .req_ready(req_ready),
        .rsp_flit(rsp_flit), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .credit_in(credit_in), .out_flit(out_flit), .out_valid(out_valid), .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [44:0] mk(input logic [3:0] src, input logic [3:0] dst,
                                       input logic [1:0] sf, input logic [1:0] ty,
                                       input logic vc, input logic [31:0] pay);
        return {src, dst, sf, ty, vc, pay};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (reset && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_flit actual=%0h required=none", out_flit);
            end else begin
                exp_f = sb.pop_front();
                if (out_flit !== exp_f) begin
                    errors++;
                    $display("FAIL out_flit actual=%0h required=%0h", out_flit, exp_f);
                end
            end
        end
    end

    task automatic send(input bit s, input logic [44:0] f);
        int n;
        n = 0;
        @(posedge clock); #1;
        while (!(s ? rsp_ready : req_ready) && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        chk(s ? "rsp_ready_wait" : "req_ready_wait", {63'd0, (s ? rsp_ready : req_ready)}, 64'd1);
        if (s) begin rsp_flit = f; rsp_valid = 1'b1; end
        else   begin req_flit = f; req_valid = 1'b1; end
        @(posedge clock); #1;
        req_valid = 1'b0;
        rsp_valid = 1'b0;
    endtask

    task automatic credit(input logic [1:0] m);
        credit_in = m;
        @(posedge clock); #1;
        credit_in = 2'b00;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        #1;
        chk("drain_left", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; rsp_valid = 1'b0;
        req_flit = '0; rsp_flit = '0; credit_in = 2'b00;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_flit", {19'd0, out_flit}, 64'd0);
        chk("rst_err", {62'd0, err}, 64'd0);
        chk("rst_readies", {62'd0, req_ready, rsp_ready}, 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_readies", {62'd0, req_ready, rsp_ready}, 64'd3);

        // single ALL request: vc rewritten 1->0, visible two cycles after presentation
        sb.push_back(mk(4'h3, 4'hA, 2'd1, ALL, 1'b0, 32'hDEADBEEF));
        req_flit = mk(4'h3, 4'hA, 2'd1, ALL, 1'b1, 32'hDEADBEEF);
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(negedge clock);
        chk("latency_t1", {63'd0, out_valid}, 64'd0);
        @(negedge clock);
        chk("latency_t2", {63'd0, out_valid}, 64'd1);
        drain();
        credit(2'b01);

        // lone response moves rr to RSP
        sb.push_back(mk(4'h5, 4'h1, 2'd2, ALL, 1'b1, 32'h11112222));
        send(1'b1, mk(4'h5, 4'h1, 2'd2, ALL, 1'b0, 32'h11112222));
        drain();
        credit(2'b10);

        // REQ packet vs RSP ALL: packet is contiguous, ALL follows TAIL
        sb.push_back(mk(4'h1, 4'h2, 2'd0, HEAD, 1'b0, 32'hA0));
        sb.push_back(mk(4'h1, 4'h2, 2'd0, BODY, 1'b0, 32'hA1));
        sb.push_back(mk(4'h1, 4'h2, 2'd0, TAIL, 1'b0, 32'hA2));
        sb.push_back(mk(4'h7, 4'h8, 2'd3, ALL, 1'b1, 32'hB0));
        @(posedge clock); #1;
        req_flit = mk(4'h1, 4'h2, 2'd0, HEAD, 1'b1, 32'hA0); req_valid = 1'b1;
        rsp_flit = mk(4'h7, 4'h8, 2'd3, ALL, 1'b0, 32'hB0);  rsp_valid = 1'b1;
        @(posedge clock); #1;
        rsp_valid = 1'b0;
        req_flit = mk(4'h1, 4'h2, 2'd0, BODY, 1'b1, 32'hA1);
        @(posedge clock); #1;
        req_flit = mk(4'h1, 4'h2, 2'd0, TAIL, 1'b1, 32'hA2);
        @(posedge clock); #1;
        req_valid = 1'b0;
        drain();
        credit(2'b11); credit(2'b01); credit(2'b01);

        // lone REQ sets rr=REQ, so the following tie goes to RSP
        sb.push_back(mk(4'h2, 4'h3, 2'd1, ALL, 1'b0, 32'hC0));
        send(1'b0, mk(4'h2, 4'h3, 2'd1, ALL, 1'b0, 32'hC0));
        drain();
        sb.push_back(mk(4'h6, 4'h4, 2'd2, ALL, 1'b1, 32'hD1));
        sb.push_back(mk(4'h2, 4'h3, 2'd0, ALL, 1'b0, 32'hD0));
        @(posedge clock); #1;
        req_flit = mk(4'h2, 4'h3, 2'd0, ALL, 1'b0, 32'hD0); req_valid = 1'b1;
        rsp_flit = mk(4'h6, 4'h4, 2'd2, ALL, 1'b0, 32'hD1); rsp_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0; rsp_valid = 1'b0;
        drain();
        credit(2'b11); credit(2'b01);

        // VC1 credit exhaustion: 4 go, 5th held while VC0 still flows
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb.push_back(mk(4'h9, 4'h0, 2'd3, ALL, 1'b1, 32'(i)));
            send(1'b1, mk(4'h9, 4'h0, 2'd3, ALL, 1'b0, 32'(i)));
        end
        sb.push_back(mk(4'h4, 4'h4, 2'd0, ALL, 1'b0, 32'hE0));
        send(1'b0, mk(4'h4, 4'h4, 2'd0, ALL, 1'b1, 32'hE0));
        drain();
        repeat (5) @(posedge clock);
        #1;
        sb.push_back(mk(4'h9, 4'h0, 2'd3, ALL, 1'b1, 32'd4));
        credit(2'b10);
        @(posedge clock);
        @(negedge clock);
        chk("credit_release", {63'd0, out_valid}, 64'd1);
        drain();
        credit(2'b01);

        // same-edge send and credit return on VC0 at credit 2
        sb.push_back(mk(4'hA, 4'hB, 2'd1, ALL, 1'b0, 32'hF0));
        send(1'b0, mk(4'hA, 4'hB, 2'd1, ALL, 1'b0, 32'hF0));
        sb.push_back(mk(4'hA, 4'hB, 2'd1, ALL, 1'b0, 32'hF1));
        send(1'b0, mk(4'hA, 4'hB, 2'd1, ALL, 1'b0, 32'hF1));
        drain();
        sb.push_back(mk(4'hA, 4'hB, 2'd1, ALL, 1'b0, 32'hF2));
        req_flit = mk(4'hA, 4'hB, 2'd1, ALL, 1'b0, 32'hF2); req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        credit(2'b01);
        drain();
        chk("err_after_same_edge", {62'd0, err}, 64'd0);
        credit(2'b01); credit(2'b01);
        chk("err_after_refill", {62'd0, err}, 64'd0);
        credit(2'b01);
        chk("err_spurious_credit", {62'd0, err}, 64'd2);

        // VC1 has no credit: three back-to-back pushes overflow the RSP FIFO
        @(posedge clock); #1;
        rsp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rsp_flit = mk(4'hC, 4'hD, 2'd2, ALL, 1'b0, 32'(16 + i));
            @(posedge clock); #1;
        end
        rsp_valid = 1'b0;
        chk("err_overflow", {62'd0, err}, 64'd3);
        chk("rsp_ready_full", {63'd0, rsp_ready}, 64'd0);

        // reset while locked to REQ, BODY on the wire
        sb.push_back(mk(4'h1, 4'hF, 2'd0, HEAD, 1'b0, 32'h100));
        send(1'b0, mk(4'h1, 4'hF, 2'd0, HEAD, 1'b0, 32'h100));
        req_flit = mk(4'h1, 4'hF, 2'd0, BODY, 1'b0, 32'h101); req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        chk("body_on_wire", {63'd0, out_valid}, 64'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_flit", {19'd0, out_flit}, 64'd0);
        chk("async_rst_err", {62'd0, err}, 64'd0);
        chk("sb_empty_at_rst", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rerst_readies", {62'd0, req_ready, rsp_ready}, 64'd3);

        // full credits, empty FIFOs and released lock after reset
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk(4'h8, 4'h2, 2'd2, ALL, 1'b1, 32'(32 + i)));
            send(1'b1, mk(4'h8, 4'h2, 2'd2, ALL, 1'b0, 32'(32 + i)));
        end
        drain();
        repeat (4) @(posedge clock);
        #1;
        chk("final_err", {62'd0, err}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
